extend_scheduler: RTL and testbench
===================================

EXTEND_SCHEDULER -- requirements
Module: extend_scheduler

Interface
REQ-001 SHALL have parameter INDICES_COUNT, default 2, k-mer slots per batch (fixed extender lane count).
REQ-002 SHALL have parameter INDICE_LEN, default 5, k-mer index width.
REQ-003 SHALL have parameter FRAG_LEN, default 8, bases per extended fragment.
REQ-004 SHALL have parameter BASE_LEN, default 4, bits per base.
REQ-005 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  in  1  index offered.
REQ-008 SHALL have port in_ready  out  1  index accepted when in_valid&&in_ready at a rising edge.
REQ-009 SHALL have port in_index  in  INDICE_LEN  k-mer start index.
REQ-010 SHALL have port in_last  in  1  accepted index closes the current batch and stream.
REQ-011 SHALL have port ext_indices  out  INDICES_COUNT*INDICE_LEN  registered index slots driven to the external extender; slot s at bits [s*INDICE_LEN +: INDICE_LEN].
REQ-012 SHALL have port ext_kmers  in  INDICES_COUNT*FRAG_LEN*BASE_LEN  combinational extender result per slot.
REQ-013 SHALL have port out_valid  out  1  fragment presented.
REQ-014 SHALL have port out_ready  in  1  fragment consumed when out_valid&&out_ready at a rising edge.
REQ-015 SHALL have port out_frag  out  FRAG_LEN*BASE_LEN  extended fragment.
REQ-016 SHALL have port out_index  out  INDICE_LEN  index that produced out_frag.
REQ-017 SHALL have port out_last  out  1  final fragment of an in_last-closed batch.
REQ-018 SHALL have port busy  out  1  high in CAPTURE or DRAIN.

Function
REQ-019 SHALL implement registered FSM states COLLECT, CAPTURE, DRAIN; in_ready = (state==COLLECT).
REQ-020 SHALL in COLLECT write each accepted index into slot cnt of ext_indices and increment cnt; unfilled slots drive 0.
REQ-021 SHALL move COLLECT->CAPTURE on the edge accepting slot INDICES_COUNT-1 or any index with in_last=1, latching batch size n=cnt+1 and last flag.
REQ-022 SHALL in CAPTURE (exactly one cycle) register all ext_kmers slots and indices into a capture buffer, then enter DRAIN.
REQ-023 SHALL assert out_valid in DRAIN only; first out_valid visible after the second rising edge following the batch-closing acceptance.
REQ-024 SHALL present slots in order 0..n-1, advancing on each out_valid&&out_ready.
REQ-025 SHALL hold out_frag, out_index, out_last stable while out_valid&&!out_ready.
REQ-026 SHALL assert out_last only on slot n-1 of a batch closed by in_last.
REQ-027 SHALL return DRAIN->COLLECT on consuming slot n-1, clearing cnt and ext_indices to 0.
REQ-028 SHALL not overlap batches: no index accepted in CAPTURE or DRAIN.
REQ-029 SHALL treat in_last with cnt=0 as a valid batch of n=1.

Reset
REQ-030 SHALL on rst_n low immediately force state COLLECT, cnt 0, ext_indices 0, out_valid 0, out_frag 0, out_index 0, out_last 0, busy 0, discarding any in-flight batch.
REQ-031 SHALL drive in_ready 1 from the first edge after rst_n deasserts.

Configuration
REQ-032 SHALL, with EXTEND_SCHED_STATS_EN defined, add output frag_count (16 bits), reset 0, incrementing on each out_valid&&out_ready, wrapping 0xFFFF->0.
REQ-033 SHALL, without EXTEND_SCHED_STATS_EN, omit frag_count and its counter entirely.

Verification
REQ-034 SHALL cover: indices 3,10 (no last) -> ext_indices slot0=3, slot1=10; two fragments, out_index 3 then 10, out_last 0, out_frag equals captured ext_kmers slots.
REQ-035 SHALL cover: single index 7 with in_last -> ext_indices slot1=0, one fragment out_index 7, out_last 1, back to COLLECT.
REQ-036 SHALL cover: out_ready low 5 cycles in DRAIN -> out_frag/out_index constant, in_ready 0, no acceptance despite in_valid 1.
REQ-037 SHALL cover: rst_n low mid-DRAIN -> out_valid 0, busy 0, ext_indices 0 at once; next batch 1,2 drains correctly.
REQ-038 SHALL cover: ext_kmers changed during DRAIN -> out_frag unchanged (captured value).
REQ-039 SHALL cover (EXTEND_SCHED_STATS_EN defined): three full batches consumed -> frag_count 6.

Source files
------------

// File: rtl/extend_scheduler.sv
// rtl/extend_scheduler.sv - batches k-mer indices to a fixed-lane extender and drains fragments in order
// Optional fragment counter: define EXTEND_SCHED_STATS_EN.
module extend_scheduler #(
    parameter int INDICES_COUNT = 2,
    parameter int INDICE_LEN    = 5,
    parameter int FRAG_LEN      = 8,
    parameter int BASE_LEN      = 4
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [INDICE_LEN-1:0]                    in_index,
    input  logic                                     in_last,
    output logic [INDICES_COUNT*INDICE_LEN-1:0]      ext_indices,
    input  logic [INDICES_COUNT*FRAG_LEN*BASE_LEN-1:0] ext_kmers,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [FRAG_LEN*BASE_LEN-1:0]             out_frag,
    output logic [INDICE_LEN-1:0]                    out_index,
    output logic                                     out_last,
    output logic                                     busy
`ifdef EXTEND_SCHED_STATS_EN
    ,
    output logic [15:0]                              frag_count
`endif
);

    localparam int CW = $clog2(INDICES_COUNT + 1);
    localparam int FW = FRAG_LEN * BASE_LEN;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]         cnt;
    logic [CW-1:0]         n;
    logic [CW-1:0]         rd;
    logic                  batch_last;
    logic [FW-1:0]         cap_frag [INDICES_COUNT];
    logic [INDICE_LEN-1:0] cap_idx  [INDICES_COUNT];

    logic accept;
    logic close_batch;
    logic consume;
    logic drain_done;

    assign in_ready    = (state == COLLECT);
    assign busy        = (state != COLLECT);
    assign out_valid   = (state == DRAIN);
    assign accept      = in_valid && in_ready;
    assign close_batch = accept && (in_last || (cnt == CW'(INDICES_COUNT - 1)));
    assign consume     = out_valid && out_ready;
    assign drain_done  = consume && (rd == n - CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (close_batch) state_nxt = CAPTURE;
            CAPTURE: state_nxt = DRAIN;
            DRAIN:   if (drain_done) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            n           <= '0;
            rd          <= '0;
            batch_last  <= 1'b0;
            ext_indices <= '0;
            for (int s = 0; s < INDICES_COUNT; s++) begin
                cap_frag[s] <= '0;
                cap_idx[s]  <= '0;
            end
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        for (int s = 0; s < INDICES_COUNT; s++) begin
                            if (cnt == CW'(s)) ext_indices[s*INDICE_LEN +: INDICE_LEN] <= in_index;
                        end
                        cnt <= cnt + CW'(1);
                        if (close_batch) begin
                            n          <= cnt + CW'(1);
                            batch_last <= in_last;
                        end
                    end
                    rd <= '0;
                end
                CAPTURE: begin
                    // Freeze the extender output so later changes on ext_kmers cannot leak into DRAIN.
                    for (int s = 0; s < INDICES_COUNT; s++) begin
                        cap_frag[s] <= ext_kmers[s*FW +: FW];
                        cap_idx[s]  <= ext_indices[s*INDICE_LEN +: INDICE_LEN];
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        cnt         <= '0;
                        rd          <= '0;
                        ext_indices <= '0;
                    end else if (consume) begin
                        rd <= rd + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        out_frag  = '0;
        out_index = '0;
        out_last  = 1'b0;
        if (state == DRAIN) begin
            for (int s = 0; s < INDICES_COUNT; s++) begin
                if (rd == CW'(s)) begin
                    out_frag  = cap_frag[s];
                    out_index = cap_idx[s];
                end
            end
            out_last = batch_last && (rd == n - CW'(1));
        end
    end

`ifdef EXTEND_SCHED_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frag_count <= '0;
        end else if (consume) begin
            frag_count <= frag_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_extend_scheduler.sv
// tb/tb_extend_scheduler.sv - table-driven and directed checks for extend_scheduler
module tb_extend_scheduler;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_index;
    logic        in_last;
    logic [9:0]  ext_indices;
    logic [63:0] ext_kmers;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_frag;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;
`ifdef EXTEND_SCHED_STATS_EN
    logic [15:0] frag_count;
`endif

    logic [31:0] salt;
    int tests;
    int fails;

    extend_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_index   (in_index),
        .in_last    (in_last),
        .ext_indices(ext_indices),
        .ext_kmers  (ext_kmers),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_frag   (out_frag),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy)
`ifdef EXTEND_SCHED_STATS_EN
        ,
        .frag_count (frag_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] kfun(input logic [4:0] i, input logic [31:0] s);
        return {i, 3'b101, i, 3'b010, i, 3'b111, i, 3'b000} ^ s;
    endfunction

    // Behavioural extender: fragment is a fixed function of the slot index and the current salt.
    always_comb begin
        ext_kmers = '0;
        for (int s = 0; s < 2; s++) begin
            ext_kmers[s*32 +: 32] = kfun(ext_indices[s*5 +: 5], salt);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] idx, input logic last);
        int guard;
        in_valid = 1'b1;
        in_index = idx;
        in_last  = last;
        guard    = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0] n;
        logic [4:0] i0;
        logic [4:0] i1;
        logic       last;
        logic [9:0] exp_ext;
    } vec_t;

    vec_t vecs [4];

    // Sends one batch, checks the CAPTURE cycle and drains with out_ready high.
    task automatic run_batch(input vec_t v);
        logic [4:0] idxs [2];
        idxs[0] = v.i0;
        idxs[1] = v.i1;
        out_ready = 1'b1;
        if (v.n == 2'd1) begin
            send(v.i0, v.last);
        end else begin
            send(v.i0, 1'b0);
            chk("ext_slot0_partial", 64'(ext_indices), 64'({5'd0, v.i0}));
            send(v.i1, v.last);
        end
        chk("cap_ext_indices", 64'(ext_indices), 64'(v.exp_ext));
        chk("cap_out_valid", 64'(out_valid), 64'd0);
        chk("cap_busy", 64'(busy), 64'd1);
        chk("cap_in_ready", 64'(in_ready), 64'd0);
        step();
        for (int s = 0; s < int'(v.n); s++) begin
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            chk("drain_out_index", 64'(out_index), 64'(idxs[s]));
            chk("drain_out_frag", 64'(out_frag), 64'(kfun(idxs[s], salt)));
            chk("drain_out_last", 64'(out_last), 64'(v.last && (s == int'(v.n) - 1)));
            step();
        end
        chk("post_in_ready", 64'(in_ready), 64'd1);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_ext_indices", 64'(ext_indices), 64'd0);
    endtask

    logic [31:0] held_frag;

    initial begin
        tests     = 0;
        fails     = 0;
        salt      = 32'h0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{n: 2'd2, i0: 5'd3,  i1: 5'd10, last: 1'b0, exp_ext: 10'b01010_00011};
        vecs[1] = '{n: 2'd1, i0: 5'd7,  i1: 5'd0,  last: 1'b1, exp_ext: 10'b00000_00111};
        vecs[2] = '{n: 2'd2, i0: 5'd31, i1: 5'd0,  last: 1'b1, exp_ext: 10'b00000_11111};
        vecs[3] = '{n: 2'd2, i0: 5'd5,  i1: 5'd6,  last: 1'b0, exp_ext: 10'b00110_00101};

        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ext_indices", 64'(ext_indices), 64'd0);
        chk("rst_out_frag", 64'(out_frag), 64'd0);
        chk("rst_out_index", 64'(out_index), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        for (int k = 0; k < 4; k++) begin
            salt = 32'h1111_0000 * k;
            run_batch(vecs[k]);
        end

        // Backpressure in DRAIN with a changing extender output and a pending index.
        salt = 32'h0BAD_F00D;
        send(5'd3, 1'b0);
        send(5'd10, 1'b0);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_index  = 5'd9;
        held_frag = kfun(5'd3, 32'h0BAD_F00D);
        salt      = 32'h1234_5678;
        for (int c = 0; c < 5; c++) begin
            chk("stall_out_index", 64'(out_index), 64'd3);
            chk("stall_out_frag", 64'(out_frag), 64'(held_frag));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_out_valid", 64'(out_valid), 64'd1);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("stall2_out_index", 64'(out_index), 64'd10);
        chk("stall2_out_frag", 64'(out_frag), 64'(kfun(5'd10, 32'h0BAD_F00D)));
        step();
        chk("stall_no_accept", 64'(ext_indices), 64'd0);
        chk("stall_back_collect", 64'(in_ready), 64'd1);

        // Reset asserted while a batch is draining.
        salt = 32'h0;
        send(5'd4, 1'b0);
        send(5'd8, 1'b0);
        out_ready = 1'b0;
        step();
        chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ext_indices", 64'(ext_indices), 64'd0);
        chk("midrst_out_frag", 64'(out_frag), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        run_batch('{n: 2'd2, i0: 5'd1, i1: 5'd2, last: 1'b0, exp_ext: 10'b00010_00001});
        run_batch(vecs[0]);
        run_batch(vecs[3]);
`ifdef EXTEND_SCHED_STATS_EN
        chk("frag_count", 64'(frag_count), 64'd6);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
